sle_pipe_bank: RTL and testbench
================================

SLE_PIPE_BANK -- requirements
Module: sle_pipe_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data width in bits (1..64).
REQ-002 The block SHALL have parameter DEPTH, default 4, number of register stages (2..16).
REQ-003 The block SHALL have parameter SD_VAL, default {WIDTH{1'b0}}, synchronous-load data value.
REQ-004 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-005 CLK  input  1  clock; all state changes on rising edge.
REQ-006 RST  input  1  synchronous active-high reset.
REQ-007 EN  input  1  clock enable; 0 = all state holds.
REQ-008 SLn  input  1  active-low synchronous load, qualified by EN.
REQ-009 D  input  WIDTH  data into stage 0.
REQ-010 D_VLD  input  1  valid flag accompanying D.
REQ-011 TAP  input  $clog2(DEPTH)  selects the stage driving Q.
REQ-012 Q  output  WIDTH  data of selected stage.
REQ-013 Q_VLD  output  1  valid flag of selected stage.
REQ-014 FILL  output  $clog2(DEPTH+1)  number of stages currently holding valid data.

Function
REQ-015 The block SHALL hold DEPTH data registers S[0..DEPTH-1] (WIDTH bits) and DEPTH valid bits V[0..DEPTH-1].
REQ-016 Per-edge priority SHALL be: RST, then EN=0 (hold), then SLn=0 (load), then shift.
REQ-017 Shift (RST=0, EN=1, SLn=1): S[0]<=D, V[0]<=D_VLD, S[k]<=S[k-1], V[k]<=V[k-1] for k=1..DEPTH-1; S[DEPTH-1]/V[DEPTH-1] old contents discarded.
REQ-018 Load (RST=0, EN=1, SLn=0): all S[k]<=SD_VAL, all V[k]<=0, FILL<=0; D and D_VLD ignored.
REQ-019 Hold (RST=0, EN=0): S, V, FILL unchanged regardless of SLn, D, D_VLD.
REQ-020 Q SHALL be combinational S[TAP], Q_VLD SHALL be combinational V[TAP]; TAP >= DEPTH SHALL select stage DEPTH-1.
REQ-021 Latency D->Q SHALL be TAP+1 enabled rising edges; TAP changes SHALL affect Q in the same cycle.
REQ-022 FILL SHALL be a registered counter: on shift FILL <= FILL + D_VLD - V[DEPTH-1]; unchanged on hold.
REQ-023 FILL SHALL always equal the population count of V and SHALL stay in 0..DEPTH; no wrap-around.
REQ-024 Full pipe (FILL=DEPTH) with D_VLD=1 and shift SHALL keep FILL=DEPTH; empty pipe with D_VLD=0 SHALL keep FILL=0.
REQ-025 Invalid data (D_VLD=0) SHALL still be shifted into S[0]; only V marks it invalid.
REQ-026 X on D while D_VLD=0 is permitted; no X on EN, SLn, RST, TAP.

Reset
REQ-027 With RST=1 at a rising edge: S[k]<=0, V[k]<=0, FILL<=0, regardless of EN and SLn.
REQ-028 After reset Q SHALL read 0 and Q_VLD 0 for every TAP.
REQ-029 RST asserted mid-stream SHALL discard all in-flight data; first shift after release SHALL be treated as into an empty pipe.
REQ-030 Before the first RST edge outputs are undefined; benches SHALL apply RST for >=2 cycles.

Verification (WIDTH=8, DEPTH=4, SD_VAL=8'hA5)
REQ-031 Reset, EN=1 SLn=1 TAP=3, D=8'h11/22/33/44 with D_VLD=1 on 4 edges -> Q=8'h11, Q_VLD=1 after 4th edge, FILL=4.
REQ-032 Pipe full as above, EN=0 for 3 edges with D=8'hFF, SLn=0 -> Q, Q_VLD, FILL unchanged (8'h11, 1, 4).
REQ-033 Pipe full, EN=1 SLn=0 one edge -> all TAP values read 8'hA5, Q_VLD=0, FILL=0; next shift with D=8'h5A D_VLD=1 -> TAP=0 reads 8'h5A, FILL=1.
REQ-034 Pipe full, shift D_VLD=0 D=8'h00 four edges -> FILL steps 3,2,1,0; TAP=3 Q_VLD=0 after 4th edge.
REQ-035 Pipe holding 8'h11..8'h44, sweep TAP 0..3 with EN=0 -> Q=8'h44,8'h33,8'h22,8'h11 in same cycle as TAP change.
REQ-036 Pipe full, RST=1 with EN=1 SLn=0 simultaneously -> Q=0, Q_VLD=0, FILL=0 (reset wins); then single shift D=8'h77 D_VLD=1 -> FILL=1.

Source files
------------

// File: rtl/sle_pipe_bank.sv
// Shift-register bank: DEPTH stages with per-stage valid bits, synchronous load and a tapped output.
// Data reaches Q TAP+1 enabled edges after entry; EN=0 freezes all state, with no backpressure beyond that.
module sle_pipe_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter logic [WIDTH-1:0] SD_VAL = {WIDTH{1'b0}}
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       EN,
    input  logic                       SLn,
    input  logic [WIDTH-1:0]           D,
    input  logic                       D_VLD,
    input  logic [$clog2(DEPTH)-1:0]   TAP,
    output logic [WIDTH-1:0]           Q,
    output logic                       Q_VLD,
    output logic [$clog2(DEPTH+1)-1:0] FILL
);
    localparam int TW   = $clog2(DEPTH);
    localparam int FW   = $clog2(DEPTH + 1);
    localparam int NTAP = 1 << TW;

    logic [WIDTH-1:0] stage [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [FW-1:0]    fill_q;
    logic [FW-1:0]    fill_nxt;
    logic [WIDTH-1:0] q_map [NTAP];
    logic [NTAP-1:0]  v_map;

    // One entering, one leaving: counter tracks popcount(vld) without a wide adder tree.
    always_comb fill_nxt = fill_q + FW'(D_VLD) - FW'(vld[DEPTH-1]);

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
            vld    <= '0;
            fill_q <= '0;
        end else if (EN) begin
            if (!SLn) begin
                for (int k = 0; k < DEPTH; k++) stage[k] <= SD_VAL;
                vld    <= '0;
                fill_q <= '0;
            end else begin
                stage[0] <= D;
                for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
                vld    <= {vld[DEPTH-2:0], D_VLD};
                fill_q <= fill_nxt;
            end
        end
    end

    // Tap codes past the last stage alias onto it, so the mux never reads off the end.
    for (genvar i = 0; i < NTAP; i++) begin : g_map
        localparam int SRC = (i < DEPTH) ? i : DEPTH - 1;
        assign q_map[i] = stage[SRC];
        assign v_map[i] = vld[SRC];
    end

    assign Q     = q_map[TAP];
    assign Q_VLD = v_map[TAP];
    assign FILL  = fill_q;

endmodule

// File: tb/tb_sle_pipe_bank.sv
// Scoreboard bench for sle_pipe_bank (WIDTH=8, DEPTH=4, SD_VAL=8'hA5).
module tb_sle_pipe_bank;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       EN = 1'b0;
    logic       SLn = 1'b1;
    logic [7:0] D = 8'h00;
    logic       D_VLD = 1'b0;
    logic [1:0] TAP = 2'd0;
    logic [7:0] Q;
    logic       Q_VLD;
    logic [2:0] FILL;

    sle_pipe_bank #(.WIDTH(8), .DEPTH(4), .SD_VAL(8'hA5)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .SLn(SLn), .D(D), .D_VLD(D_VLD),
        .TAP(TAP), .Q(Q), .Q_VLD(Q_VLD), .FILL(FILL)
    );

    always #20 CLK = ~CLK;

    typedef struct {
        logic [1:0] tap;
        logic [7:0] q;
        logic       qv;
        logic [2:0] fill;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_s [4];
    logic [3:0] m_v;
    int         checks = 0;
    int         failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one edge, advance the reference model, queue expectations for every tap, then drain.
    task automatic edge_op(input logic rst, input logic en, input logic sln,
                           input logic [7:0] d, input logic dvld);
        exp_t e;
        @(negedge CLK);
        RST = rst; EN = en; SLn = sln; D = d; D_VLD = dvld;
        if (rst) begin
            for (int k = 0; k < 4; k++) m_s[k] = 8'h00;
            m_v = 4'b0000;
        end else if (en) begin
            if (!sln) begin
                for (int k = 0; k < 4; k++) m_s[k] = 8'hA5;
                m_v = 4'b0000;
            end else begin
                for (int k = 3; k > 0; k--) m_s[k] = m_s[k-1];
                m_s[0] = d;
                m_v = {m_v[2:0], dvld};
            end
        end
        for (int t = 0; t < 4; t++) begin
            e.tap = 2'(t); e.q = m_s[t]; e.qv = m_v[t]; e.fill = 3'($countones(m_v));
            sb.push_back(e);
        end
        @(posedge CLK);
        #1;
        EN = 1'b0; RST = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            TAP = e.tap;
            #1;
            check("sb_q", 32'(Q), 32'(e.q));
            check("sb_qvld", 32'(Q_VLD), 32'(e.qv));
            check("sb_fill", 32'(FILL), 32'(e.fill));
        end
    endtask

    task automatic at_tap(input string tag, input logic [1:0] t, input logic [7:0] q,
                          input logic qv, input logic [2:0] fill);
        TAP = t;
        #1;
        check({tag, "_q"}, 32'(Q), 32'(q));
        check({tag, "_qvld"}, 32'(Q_VLD), 32'(qv));
        check({tag, "_fill"}, 32'(FILL), 32'(fill));
    endtask

    initial begin
        logic [7:0] pat [4];
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
        for (int k = 0; k < 4; k++) m_s[k] = 8'h00;
        m_v = 4'b0000;

        // Reset must win whatever EN/SLn do.
        edge_op(1'b1, 1'b0, 1'b0, 8'hFF, 1'b1);
        edge_op(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1);
        for (int t = 0; t < 4; t++) at_tap("reset", 2'(t), 8'h00, 1'b0, 3'd0);

        for (int i = 0; i < 4; i++) edge_op(1'b0, 1'b1, 1'b1, pat[i], 1'b1);
        at_tap("fill4", 2'd3, 8'h11, 1'b1, 3'd4);

        for (int i = 0; i < 3; i++) edge_op(1'b0, 1'b0, 1'b0, 8'hFF, 1'b1);
        at_tap("hold", 2'd3, 8'h11, 1'b1, 3'd4);
        for (int t = 0; t < 4; t++) at_tap("sweep", 2'(t), pat[3-t], 1'b1, 3'd4);

        edge_op(1'b0, 1'b1, 1'b0, 8'hFF, 1'b1);
        at_tap("load0", 2'd0, 8'hA5, 1'b0, 3'd0);
        at_tap("load3", 2'd3, 8'hA5, 1'b0, 3'd0);
        edge_op(1'b0, 1'b1, 1'b1, 8'h5A, 1'b1);
        at_tap("after_load", 2'd0, 8'h5A, 1'b1, 3'd1);

        for (int i = 0; i < 4; i++) edge_op(1'b0, 1'b1, 1'b1, pat[i], 1'b1);
        at_tap("full_saturate", 2'd0, 8'h44, 1'b1, 3'd4);
        edge_op(1'b0, 1'b1, 1'b1, 8'h99, 1'b1);
        check("full_stays", 32'(FILL), 32'd4);

        for (int i = 0; i < 4; i++) begin
            edge_op(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
            check("drain_fill", 32'(FILL), 32'(3 - i));
        end
        at_tap("drained", 2'd3, 8'h00, 1'b0, 3'd0);
        edge_op(1'b0, 1'b1, 1'b1, 8'h3C, 1'b0);
        at_tap("empty_stays", 2'd0, 8'h3C, 1'b0, 3'd0);

        for (int i = 0; i < 16; i++)
            edge_op(1'b0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0),
                    8'($urandom), 1'($urandom));

        for (int i = 0; i < 4; i++) edge_op(1'b0, 1'b1, 1'b1, pat[i], 1'b1);
        edge_op(1'b1, 1'b1, 1'b0, 8'hEE, 1'b1);
        at_tap("rst_wins", 2'd3, 8'h00, 1'b0, 3'd0);
        edge_op(1'b0, 1'b1, 1'b1, 8'h77, 1'b1);
        at_tap("post_rst", 2'd0, 8'h77, 1'b1, 3'd1);
        at_tap("post_rst3", 2'd3, 8'h00, 1'b0, 3'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
